// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed big-endian data memory behind a req/done handshake.
// Latency: req to done is LATENCY+1 cycles (errors respond after 1); one access per LATENCY+2 cycles.
// Backpressure: req is only sampled in IDLE; busy is high otherwise. Optional stats: DMEM_CTRL_STATS_EN.
module dmem_ctrl #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [0:31] addr,
  input  logic        write_enable,
  input  logic        byte_access,   // byte-sized access; "byte" is a reserved word
  input  logic        half_word,
  input  logic        sign_extend,
  input  logic [0:31] data_in,
  output logic [0:31] data_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [0:15] rd_count,
  output logic [0:15] wr_count,
  output logic [0:15] err_count
);

  localparam int AW = $clog2(SIZE);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt;
  logic [0:31]   addr_q, data_q;
  logic          we_q, byte_q, half_q, sext_q, err_q;

  // Effective request: the live inputs while IDLE (so a zero-latency access
  // can commit on its acceptance edge), the latched copy afterwards.
  logic [0:31]   cur_addr, cur_data;
  logic          cur_we, cur_byte, cur_half, cur_sext, cur_ill, commit;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_val;

  logic [7:0]    mem [0:SIZE-1];

  // Select request source and decode legality, indices and load data
  always_comb begin
    cur_addr = (state == IDLE) ? addr         : addr_q;
    cur_data = (state == IDLE) ? data_in      : data_q;
    cur_we   = (state == IDLE) ? write_enable : we_q;
    cur_byte = (state == IDLE) ? byte_access  : byte_q;
    cur_half = (state == IDLE) ? half_word    : half_q;
    cur_sext = (state == IDLE) ? sign_extend  : sext_q;
    cur_ill  = (!cur_byte && cur_half && cur_addr[31]) ||
               (!cur_byte && !cur_half && (cur_addr[30:31] != 2'b00)) ||
               (cur_addr >= 32'(SIZE));
    commit   = (state_nxt == RESP) && !cur_ill;
    idx0     = cur_addr[32-AW:31];
    idx1     = idx0 + AW'(1);
    idx2     = idx0 + AW'(2);
    idx3     = idx0 + AW'(3);
    b0       = mem[idx0];
    b1       = mem[idx1];
    b2       = mem[idx2];
    b3       = mem[idx3];
    if (cur_byte)
      load_val = {((cur_sext && b0[7]) ? 24'hFF_FFFF : 24'h0), b0};
    else if (cur_half)
      load_val = {((cur_sext && b0[7]) ? 16'hFFFF : 16'h0), b0, b1};
    else
      load_val = {b0, b1, b2, b3};
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: illegal requests skip the wait states entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (cur_ill || LATENCY == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: done/error only exist in RESP
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == RESP);
    error = (state == RESP) && err_q;
  end

  // Capture the request while IDLE; the copy is frozen once we leave IDLE
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      addr_q <= addr;
      data_q <= data_in;
      we_q   <= write_enable;
      byte_q <= byte_access;
      half_q <= half_word;
      sext_q <= sign_extend;
    end
  end

  // Wait-state counter: loaded on acceptance, counts down in WAIT
  always_ff @(posedge clock) begin
    if (!reset)                    wait_cnt <= 4'd0;
    else if (state == IDLE && req) wait_cnt <= LAT_M1;
    else if (state == WAIT)        wait_cnt <= wait_cnt - 4'd1;
  end

  // Response data and error flag, captured on the edge entering RESP
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out <= '0;
      err_q    <= 1'b0;
    end else if (state_nxt == RESP) begin
      err_q    <= cur_ill;
      data_out <= (cur_ill || cur_we) ? 32'h0 : load_val;
    end
  end

  // Storage write; reset suppresses the commit so aborted stores never land
  always_ff @(posedge clock) begin
    if (reset && commit && cur_we) begin
      if (cur_byte) begin
        mem[idx0] <= cur_data[24:31];
      end else if (cur_half) begin
        mem[idx0] <= cur_data[16:23];
        mem[idx1] <= cur_data[24:31];
      end else begin
        mem[idx0] <= cur_data[0:7];
        mem[idx1] <= cur_data[8:15];
        mem[idx2] <= cur_data[16:23];
        mem[idx3] <= cur_data[24:31];
      end
    end
  end

`ifdef DMEM_CTRL_STATS_EN
  logic [15:0] rd_q, wr_q, er_q;

  // Saturating completion counters, bumped during the RESP cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
      er_q <= '0;
    end else if (state == RESP) begin
      if (err_q) begin
        if (er_q != 16'hFFFF) er_q <= er_q + 16'd1;
      end else if (we_q) begin
        if (wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
      end else begin
        if (rd_q != 16'hFFFF) rd_q <= rd_q + 16'd1;
      end
    end
  end

  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = er_q;
`else
  assign rd_count  = '0;
  assign wr_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl at LATENCY=2 and a LATENCY=0 streaming instance.
// Latency: expected req-to-done counts are hand-derived per access.
// Backpressure: the zero-latency instance sees req held high continuously.
module tb_dmem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  // LATENCY=2 instance
  logic        req = 0, write_enable = 0, byte_access = 0, half_word = 0, sign_extend = 0;
  logic [31:0] addr = 0, data_in = 0, data_out;
  logic        busy, done, error;
  logic [15:0] rd_count, wr_count, err_count;

  // LATENCY=0 instance
  logic        req0 = 0, we0 = 0;
  logic [31:0] addr0 = 0, din0 = 0, dout0;
  logic        busy0, done0, error0;
  logic [15:0] rdc0, wrc0, erc0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_rd = 0, exp_wr = 0, exp_er = 0;

  always #5 clock = ~clock;

  dmem_ctrl #(.SIZE(16384), .LATENCY(2)) u_dut (
    .clock(clock), .reset(reset), .req(req), .addr(addr),
    .write_enable(write_enable), .byte_access(byte_access), .half_word(half_word),
    .sign_extend(sign_extend), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .error(error),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  dmem_ctrl #(.SIZE(64), .LATENCY(0)) u_dut0 (
    .clock(clock), .reset(reset), .req(req0), .addr(addr0),
    .write_enable(we0), .byte_access(1'b0), .half_word(1'b0),
    .sign_extend(1'b0), .data_in(din0), .data_out(dout0),
    .busy(busy0), .done(done0), .error(error0),
    .rd_count(rdc0), .wr_count(wrc0), .err_count(erc0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sz: 0 = word, 1 = byte, 2 = half-word
  task automatic access(input string tag, input logic wr, input int sz, input logic sxt,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_e, input logic [31:0] exp_q, input int exp_lat);
    int   lat;
    logic got;
    @(negedge clock);
    req = 1; write_enable = wr; byte_access = (sz == 1); half_word = (sz == 2);
    sign_extend = sxt; addr = a; data_in = d;
    @(posedge clock);
    #1 req = 0;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (done) got = 1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(error), 32'(exp_e));
      check({tag, "_data"}, data_out, exp_q);
    end
    if (exp_e) exp_er++;
    else if (wr) exp_wr++;
    else exp_rd++;
  endtask

  task automatic check_counters(input string tag);
`ifdef DMEM_CTRL_STATS_EN
    check({tag, "_rd"}, 32'(rd_count), 32'(exp_rd));
    check({tag, "_wr"}, 32'(wr_count), 32'(exp_wr));
    check({tag, "_er"}, 32'(err_count), 32'(exp_er));
`else
    check({tag, "_rd"}, 32'(rd_count), 32'd0);
    check({tag, "_wr"}, 32'(wr_count), 32'd0);
    check({tag, "_er"}, 32'(err_count), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", data_out, 32'h0);
    check_counters("rst_cnt");
    reset = 1;

    // Word store then byte/half/word loads with both extensions
    access("st_w10",   1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 3);
    access("ld_b11s",  0, 1, 1, 32'h11, 32'h0, 0, 32'hFFFFFFAD, 3);
    access("ld_b13s",  0, 1, 1, 32'h13, 32'h0, 0, 32'hFFFFFFEF, 3);
    access("ld_b10z",  0, 1, 0, 32'h10, 32'h0, 0, 32'h000000DE, 3);
    access("ld_h12s",  0, 2, 1, 32'h12, 32'h0, 0, 32'hFFFFBEEF, 3);
    access("ld_w10",   0, 0, 1, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3);

    // Half-word store with junk upper bits, zero/sign extended loads
    access("st_h20",   1, 2, 0, 32'h20, 32'h12348001, 0, 32'h0, 3);
    access("ld_h20z",  0, 2, 0, 32'h20, 32'h0, 0, 32'h00008001, 3);
    access("ld_h20s",  0, 2, 1, 32'h20, 32'h0, 0, 32'hFFFF8001, 3);
    access("st_b13",   1, 1, 0, 32'h13, 32'hABCDEF77, 0, 32'h0, 3);
    access("ld_w10b",  0, 0, 0, 32'h10, 32'h0, 0, 32'hDEADBE77, 3);

    // Misaligned accesses: immediate error response, storage untouched
    access("ld_w22",   0, 0, 0, 32'h22, 32'h0, 1, 32'h0, 1);
    access("ld_h21",   0, 2, 0, 32'h21, 32'h0, 1, 32'h0, 1);
    check_counters("cnt_a");
    access("st_w12",   1, 0, 0, 32'h12, 32'h0, 1, 32'h0, 1);
    access("ld_w10c",  0, 0, 0, 32'h10, 32'h0, 0, 32'hDEADBE77, 3);

    // Out-of-range store
    access("st_w0",    1, 0, 0, 32'h0, 32'h11223344, 0, 32'h0, 3);
    access("st_oor",   1, 0, 0, 32'd16384, 32'hFFFFFFFF, 1, 32'h0, 1);
    access("st_oorb",  1, 1, 0, 32'd16385, 32'hFFFFFFFF, 1, 32'h0, 1);
    access("ld_w0",    0, 0, 0, 32'h0, 32'h0, 0, 32'h11223344, 3);
    check_counters("cnt_b");

    // Reset during WAIT aborts a store
    access("st_w30",   1, 0, 0, 32'h30, 32'h55667788, 0, 32'h0, 3);
    @(negedge clock);
    req = 1; write_enable = 1; byte_access = 0; half_word = 0; addr = 32'h30; data_in = 32'hA5A5A5A5;
    @(posedge clock);
    #1 req = 0;
    @(negedge clock);
    check("abort_busy_wait", 32'(busy), 32'd1);
    reset = 0;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1;
    dn = 0;
    repeat (6) begin
      @(negedge clock);
      dn += int'(done);
    end
    check("abort_no_done", 32'(dn), 32'd0);
    exp_rd = 0; exp_wr = 0; exp_er = 0;
    check_counters("cnt_rst");
    access("ld_w30",   0, 0, 0, 32'h30, 32'h0, 0, 32'h55667788, 3);

    // Zero-latency instance, req held high: stores then loads
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clock);
        check($sformatf("s%0d_done%0d", p, k), 32'(done0), 32'(k % 2));
        check($sformatf("s%0d_busy%0d", p, k), 32'(busy0), 32'(k % 2));
        if (k % 2 == 1) begin
          check($sformatf("s%0d_err%0d", p, k), 32'(error0), 32'd0);
          if (p == 1)
            check($sformatf("s1_data%0d", k), dout0, 32'hA0000000 + 32'(k - 1));
        end
        req0  = 1;
        we0   = (p == 0);
        addr0 = 32'(4 * k);
        din0  = 32'hA0000000 + 32'(k);
      end
    end
    @(negedge clock);
    req0 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
